// File: rtl/sys_defs_pkg.sv
// Shared FV memory-system types: requester-to-arbiter request and arbiter-to-bank command.
// Bank index occupies the top two bits of FV_addr; the remaining bits address within the bank.
`ifndef SYS_DEFS_FV_MACROS
`define SYS_DEFS_FV_MACROS
`define Num_Banks_FV 4
`define FV_info_bank_width 8
`endif

package sys_defs;

  localparam int FV_ADDR_W      = `FV_info_bank_width;
  localparam int FV_BANK_IDX_HI = `FV_info_bank_width - 1;
  localparam int FV_BANK_IDX_LO = `FV_info_bank_width - 2;
  localparam int FV_BANK_IDX_W  = FV_BANK_IDX_HI - FV_BANK_IDX_LO + 1;
  localparam int FV_BANK_ADDR_W = `FV_info_bank_width - 2;
  localparam int PE_TAG_W       = 4;

  typedef struct packed {
    logic                      valid;
    logic [FV_ADDR_W-1:0]      FV_addr;
    logic [PE_TAG_W-1:0]       PE_tag;
  } FV_ARB_REQ;

  typedef struct packed {
    logic                      valid;
    logic [PE_TAG_W-1:0]       PE_tag;
    logic [FV_BANK_ADDR_W-1:0] FV_Bank_addr;
  } FV_MEM_CNTL2FV_Bank_CNTL;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } fv_arb_state_e;

  function automatic logic [FV_BANK_IDX_W-1:0] fv_bank_of(input logic [FV_ADDR_W-1:0] addr);
    return addr[FV_BANK_IDX_HI:FV_BANK_IDX_LO];
  endfunction

endpackage

// File: rtl/fv_bank_arbiter_rr.sv
// Combinational one-hot pick: first requester at index >= ptr, wrapping to the lowest index.
// With ptr held at 0 this degenerates to fixed lowest-index priority.
module fv_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant
);

  logic [NUM_REQ-1:0] hi_pick;
  logic [NUM_REQ-1:0] lo_pick;
  logic               hi_found;
  logic               lo_found;

  always_comb begin
    hi_pick  = '0;
    lo_pick  = '0;
    hi_found = 1'b0;
    lo_found = 1'b0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (req[r] && (r >= int'(ptr)) && !hi_found) begin
        hi_pick[r] = 1'b1;
        hi_found   = 1'b1;
      end
      if (req[r] && !lo_found) begin
        lo_pick[r] = 1'b1;
        lo_found   = 1'b1;
      end
    end
    grant = hi_found ? hi_pick : lo_pick;
  end

endmodule

// File: rtl/fv_bank_arbiter.sv
// Per-bank IDLE->GRANT->HOLD arbiter; grant and bank command are registered, one cycle after request.
// Busy banks and the two post-grant cycles block a bank. `FV_ARB_RR_EN selects round-robin over fixed priority.
module fv_bank_arbiter
  import sys_defs::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int NUM_BANKS = `Num_Banks_FV
) (
  input  logic                    clk,
  input  logic                    reset,
  input  FV_ARB_REQ               req_in [NUM_REQ],
  input  logic [NUM_BANKS-1:0]    Bank_busy,
  output logic [NUM_REQ-1:0]      req_grant,
  output FV_MEM_CNTL2FV_Bank_CNTL FV_MEM_CNTL2FV_Bank_CNTL_out [NUM_BANKS]
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] bank_req [NUM_BANKS];
  logic [NUM_REQ-1:0] bank_gnt [NUM_BANKS];

  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      for (int r = 0; r < NUM_REQ; r++) begin
        bank_req[b][r] = req_in[r].valid &&
                         (fv_bank_of(req_in[r].FV_addr) == FV_BANK_IDX_W'(b));
      end
    end
  end

  always_comb begin
    req_grant = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      req_grant = req_grant | bank_gnt[b];
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    fv_arb_state_e             state_q;
    FV_MEM_CNTL2FV_Bank_CNTL   out_q;
    logic [NUM_REQ-1:0]        gnt_q;
    logic [NUM_REQ-1:0]        pick;
    logic [PTR_W-1:0]          ptr;
    logic [PE_TAG_W-1:0]       win_tag;
    logic [FV_BANK_ADDR_W-1:0] win_addr;

`ifdef FV_ARB_RR_EN
    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] win_idx;
    assign ptr = ptr_q;

    always_comb begin
      win_idx = '0;
      for (int r = 0; r < NUM_REQ; r++) begin
        if (pick[r]) win_idx = PTR_W'(r);
      end
    end
`else
    assign ptr = '0;
`endif

    fv_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
    ) u_arb (
      .req   (bank_req[b]),
      .ptr   (ptr),
      .grant (pick)
    );

    always_comb begin
      win_tag  = '0;
      win_addr = '0;
      for (int r = 0; r < NUM_REQ; r++) begin
        if (pick[r]) begin
          win_tag  = req_in[r].PE_tag;
          win_addr = req_in[r].FV_addr[FV_BANK_ADDR_W-1:0];
        end
      end
    end

    // GRANT and HOLD ignore requests and busy: covers requester drop and bank busy-assert latency.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_q <= IDLE;
        out_q   <= '0;
        gnt_q   <= '0;
`ifdef FV_ARB_RR_EN
        ptr_q   <= '0;
`endif
      end else begin
        case (state_q)
          IDLE: begin
            if (!Bank_busy[b] && (|bank_req[b])) begin
              state_q <= GRANT;
              out_q   <= '{valid: 1'b1, PE_tag: win_tag, FV_Bank_addr: win_addr};
              gnt_q   <= pick;
`ifdef FV_ARB_RR_EN
              ptr_q   <= (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
`endif
            end else begin
              out_q <= '0;
              gnt_q <= '0;
            end
          end
          GRANT: begin
            state_q <= HOLD;
            out_q   <= '0;
            gnt_q   <= '0;
          end
          default: begin
            state_q <= IDLE;
            out_q   <= '0;
            gnt_q   <= '0;
          end
        endcase
      end
    end

    assign FV_MEM_CNTL2FV_Bank_CNTL_out[b] = out_q;
    assign bank_gnt[b]                     = gnt_q;
  end

endmodule

// File: tb/tb_fv_bank_arbiter.sv
// Directed bench for fv_bank_arbiter; expectations switch with FV_ARB_RR_EN.
module tb_fv_bank_arbiter;
  import sys_defs::*;

  logic                    clk;
  logic                    reset;
  FV_ARB_REQ               req_in [4];
  logic [3:0]              Bank_busy;
  logic [3:0]              req_grant;
  FV_MEM_CNTL2FV_Bank_CNTL bank_out [4];
  logic [3:0]              valid_vec;

  int n_vec;
  int n_err;

  fv_bank_arbiter #(.NUM_REQ(4), .NUM_BANKS(4)) dut (
    .clk                          (clk),
    .reset                        (reset),
    .req_in                       (req_in),
    .Bank_busy                    (Bank_busy),
    .req_grant                    (req_grant),
    .FV_MEM_CNTL2FV_Bank_CNTL_out (bank_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int b = 0; b < 4; b++) valid_vec[b] = bank_out[b].valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic [1:0] bank, input logic [5:0] addr,
                         input logic [3:0] tag);
    req_in[r].valid   = 1'b1;
    req_in[r].FV_addr = {bank, addr};
    req_in[r].PE_tag  = tag;
  endtask

  task automatic clear_reqs();
    for (int r = 0; r < 4; r++) req_in[r] = '0;
  endtask

  initial begin
    int exp_w;
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    Bank_busy = 4'b0000;
    clear_reqs();
    #1;
    check("reset_grant", 32'(req_grant), 32'h0);
    check("reset_valid", 32'(valid_vec), 32'h0);
    check("reset_bank2", 32'(bank_out[2]), 32'h0);
    cycle();
    cycle();
    reset = 1'b1;

    // Single request to bank 2, requester holds valid through GRANT and HOLD.
    set_req(0, 2'd2, 6'h15, 4'd5);
    cycle();
    check("b2_grant", 32'(req_grant), 32'h1);
    check("b2_valid", 32'(valid_vec), 32'h4);
    check("b2_tag", 32'(bank_out[2].PE_tag), 32'h5);
    check("b2_addr", 32'(bank_out[2].FV_Bank_addr), 32'h15);
    cycle();
    check("b2_hold_grant", 32'(req_grant), 32'h0);
    check("b2_hold_valid", 32'(valid_vec), 32'h0);
    cycle();
    check("b2_idle_grant", 32'(req_grant), 32'h0);
    clear_reqs();
    cycle();
    check("b2_quiet", 32'(req_grant), 32'h0);

    // Two banks granted in the same cycle.
    set_req(0, 2'd0, 6'h01, 4'd2);
    set_req(1, 2'd3, 6'h3e, 4'd3);
    cycle();
    check("dual_grant", 32'(req_grant), 32'h3);
    check("dual_valid", 32'(valid_vec), 32'h9);
    check("dual_tag3", 32'(bank_out[3].PE_tag), 32'h3);
    check("dual_addr3", 32'(bank_out[3].FV_Bank_addr), 32'h3e);
    clear_reqs();
    cycle();
    cycle();

    // Busy bank blocks its pending request; grant follows one cycle after busy drops.
    Bank_busy = 4'b0100;
    set_req(2, 2'd2, 6'h0a, 4'd9);
    for (int k = 0; k < 10; k++) begin
      cycle();
      check("busy_block", 32'(req_grant), 32'h0);
    end
    Bank_busy = 4'b0000;
    cycle();
    check("busy_release_grant", 32'(req_grant), 32'h4);
    check("busy_release_tag", 32'(bank_out[2].PE_tag), 32'h9);
    clear_reqs();
    cycle();
    cycle();

    // Four requesters contend for bank 1 continuously.
    for (int r = 0; r < 4; r++) set_req(r, 2'd1, 6'(r), 4'(r + 8));
    for (int k = 0; k < 14; k++) begin
      cycle();
`ifdef FV_ARB_RR_EN
      exp_w = (k / 3) % 4;
`else
      exp_w = 0;
`endif
      if (k % 3 == 0) begin
        check("contend_grant", 32'(req_grant), 32'(1 << exp_w));
        check("contend_tag", 32'(bank_out[1].PE_tag), 32'(exp_w + 8));
      end else begin
        check("contend_gap", 32'(req_grant), 32'h0);
      end
    end
    clear_reqs();
    cycle();
    cycle();

    // Reset asserted while bank 0 is in GRANT.
    set_req(3, 2'd0, 6'h07, 4'd7);
    cycle();
    check("pre_reset_grant", 32'(req_grant), 32'h8);
    #1;
    reset = 1'b0;
    #1;
    check("async_reset_grant", 32'(req_grant), 32'h0);
    check("async_reset_valid", 32'(valid_vec), 32'h0);
    clear_reqs();
    cycle();
    reset = 1'b1;
    #1;
    check("post_reset_grant", 32'(req_grant), 32'h0);
    // Bank 1 pointer would pick req2 and bank 2 pointer req3 if not cleared.
    set_req(0, 2'd1, 6'h00, 4'd1);
    set_req(2, 2'd1, 6'h02, 4'd4);
    set_req(1, 2'd2, 6'h11, 4'd6);
    set_req(3, 2'd2, 6'h13, 4'd12);
    cycle();
    check("post_reset_ptr_grant", 32'(req_grant), 32'h3);
    check("post_reset_b1_tag", 32'(bank_out[1].PE_tag), 32'h1);
    check("post_reset_b2_tag", 32'(bank_out[2].PE_tag), 32'h6);
    clear_reqs();
    cycle();
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fv_bank_arbiter.md
FV_BANK_ARBITER -- requirements
Module: fv_bank_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters (FV memory controllers) sharing the FV banks.
REQ-002 SHALL have parameter NUM_BANKS, default `Num_Banks_FV (4): number of FV banks arbitrated.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port req_in, input, NUM_REQ x FV_ARB_REQ: per requester valid, FV_addr[`FV_info_bank_width-1:0], PE_tag.
REQ-006 SHALL have port Bank_busy, input, NUM_BANKS: per-bank busy from the bank controllers.
REQ-007 SHALL have port req_grant, output, NUM_REQ: registered one-cycle grant pulse per requester.
REQ-008 SHALL have port FV_MEM_CNTL2FV_Bank_CNTL_out, output, NUM_BANKS x FV_MEM_CNTL2FV_Bank_CNTL: registered per-bank valid, PE_tag and FV_Bank_addr.

Function
REQ-009 SHALL decode each request's target bank from FV_addr[`FV_info_bank_width-1:`FV_info_bank_width-2]; the bank address is FV_addr[`FV_info_bank_width-3:0].
REQ-010 SHALL run one FSM per bank with states IDLE, GRANT and HOLD.
REQ-011 IDLE->GRANT SHALL occur when Bank_busy[b]==0 and at least one valid request targets bank b; otherwise the FSM SHALL stay in IDLE.
REQ-012 On entering GRANT, bank b output SHALL be valid=1 with the winner's PE_tag and bank address, and req_grant[winner]=1, both for exactly one cycle.
REQ-013 In GRANT the FSM SHALL move unconditionally to HOLD; in HOLD it SHALL move unconditionally to IDLE.
REQ-014 In GRANT and HOLD the arbiter SHALL ignore requests and Bank_busy for bank b, covering requester deassertion and the bank busy-assert latency.
REQ-015 Each requester SHALL hold req valid and all fields stable until it sees req_grant; at most one grant SHALL be issued per request.
REQ-016 Distinct banks SHALL arbitrate independently, so up to NUM_BANKS grants SHALL be possible in the same cycle.
REQ-017 Outputs for banks not in GRANT SHALL be all-zero.
REQ-018 req_grant SHALL be one-hot or zero per bank domain, and no requester SHALL be granted twice in the same cycle.
REQ-019 If Bank_busy[b] rises while the FSM is in IDLE with a request pending, no grant SHALL issue until Bank_busy[b]==0.

Reset
REQ-020 While reset==0, all bank FSMs SHALL be in IDLE, every output field and req_grant SHALL be 0, and every round-robin pointer SHALL be 0.
REQ-021 Assertion mid-operation SHALL drop any GRANT output immediately (asynchronously); requests in flight SHALL be lost and requesters SHALL re-present them.

Configuration
REQ-022 With FV_ARB_RR_EN defined, each bank SHALL hold a round-robin pointer; the winner SHALL be the first valid requester at index >= pointer, with wrap-around; on grant the pointer SHALL become winner+1 modulo NUM_REQ.
REQ-023 With FV_ARB_RR_EN undefined, arbitration SHALL be fixed priority (lowest requester index wins) and no pointer registers SHALL exist.

Structure
REQ-024 The FV_ARB_REQ typedef SHALL live in the shared sys_defs package, alongside the existing FV_MEM_CNTL2FV_Bank_CNTL; the bank-index slice positions SHALL be package constants.
REQ-025 The design SHALL contain one sub-module, fv_rr_arbiter (NUM_REQ-wide request vector, pointer input, one-hot grant output), instantiated once per bank; the per-bank FSMs SHALL stay in the top level.

Verification
REQ-026 The bench SHALL cover: req0 valid, FV_addr bank 2, PE_tag 5, bank idle -> next cycle bank2 valid=1, PE_tag=5, req_grant=4'b0001; then HOLD, no regrant while req0 is still high.
REQ-027 The bench SHALL cover: RR enabled, req0..3 all target bank 1 and each re-requests after grant -> grants in order 0,1,2,3,0, spaced 3 cycles apart.
REQ-028 The bench SHALL cover: RR disabled, same stimulus -> req0 wins repeatedly and req1..3 starve.
REQ-029 The bench SHALL cover: req0->bank0, req1->bank3, both idle -> both banks valid in the same cycle, req_grant=4'b0011.
REQ-030 The bench SHALL cover: Bank_busy[2]=1 for 10 cycles with req2 targeting bank 2 -> no grant; grant appears 1 cycle after busy falls.
REQ-031 The bench SHALL cover: reset pulled low during GRANT -> outputs 0 immediately; after release, FSMs in IDLE and pointers at 0.
